// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Accepts operands on start while idle, streams one sum bit per clock, then
// presents the parallel sum and carry-out with a one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a sub_i input and a borrow_o
// output so the same cell computes a - b (b inverted, carry-in 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
  output logic             borrow_o,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             sum_bit_o,
  output logic             sum_bit_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             done_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             sum_bit_q;
  logic             sum_bit_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  logic             s_d;
  logic             c_d;
  logic             last_d;
  logic [WIDTH-1:0] sum_bit_mask_d;

`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;
  logic             borrow_q;
`endif

  // Full-adder cell on the current LSBs, plus last-bit detect.
  always_comb begin
    s_d            = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_d            = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    last_d         = (cnt_q == CntW'(WIDTH - 1));
    sum_bit_mask_d = WIDTH'(s_d) << cnt_q;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      a_sh_q          <= '0;
      b_sh_q          <= '0;
      carry_q         <= 1'b0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      sum_bit_q       <= 1'b0;
      sum_bit_valid_q <= 1'b0;
      sum_q           <= '0;
      cout_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q           <= 1'b0;
      borrow_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Done and the streamed bit only live for one cycle.
          done_q          <= 1'b0;
          sum_bit_q       <= 1'b0;
          sum_bit_valid_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef SERIAL_ADDER_SUB_EN
            // Two's-complement subtract: invert b, carry-in of one.
            b_sh_q   <= sub_i ? ~b_i : b_i;
            carry_q  <= sub_i;
            sub_q    <= sub_i;
            borrow_q <= 1'b0;
`else
            b_sh_q  <= b_i;
            carry_q <= 1'b0;
`endif
          end
        end
        StRun: begin
          sum_bit_q       <= s_d;
          sum_bit_valid_q <= 1'b1;
          sum_q           <= sum_q | sum_bit_mask_d;
          carry_q         <= c_d;
          a_sh_q          <= a_sh_q >> 1;
          b_sh_q          <= b_sh_q >> 1;
          cnt_q           <= cnt_q + 1'b1;
          if (last_d) begin
            cout_q  <= c_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`ifdef SERIAL_ADDER_SUB_EN
            borrow_q <= sub_q & ~c_d;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign sum_bit_o       = sum_bit_q;
  assign sum_bit_valid_o = sum_bit_valid_q;
  assign sum_o           = sum_q;
  assign cout_o          = cout_q;
  assign done_o          = done_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign borrow_o        = borrow_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             sum_bit_o;
  logic             sum_bit_valid_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             done_o;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_i;
  logic             borrow_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i           (sub_i),
    .borrow_o        (borrow_o),
`endif
    .a_i             (a_i),
    .b_i             (b_i),
    .busy_o          (busy_o),
    .sum_bit_o       (sum_bit_o),
    .sum_bit_valid_o (sum_bit_valid_o),
    .sum_o           (sum_o),
    .cout_o          (cout_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operation and check every cycle through the cycle after done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eb);
    @(negedge clk);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i   = sub;
`endif
    @(negedge clk);
    start_i = 1'b0;
    a_i     = 8'h00;
    b_i     = 8'h00;
    check("accept_busy", 32'(busy_o), 32'd1);
    check("accept_valid", 32'(sum_bit_valid_o), 32'd0);
    check("accept_sum_clear", 32'(sum_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bit_valid", 32'(sum_bit_valid_o), 32'd1);
      check("bit_value", 32'(sum_bit_o), 32'(es[k]));
      check("bit_done", 32'(done_o), (k == 7) ? 32'd1 : 32'd0);
      check("bit_busy", 32'(busy_o), (k == 7) ? 32'd0 : 32'd1);
    end
    check("result_sum", 32'(sum_o), 32'(es));
    check("result_cout", 32'(cout_o), 32'(ec));
`ifdef SERIAL_ADDER_SUB_EN
    check("result_borrow", 32'(borrow_o), 32'(eb));
`else
    if (sub || eb) check("sub_unused", 32'(sub), 32'(sub)); // never reached in add tests
`endif
    @(negedge clk);
    check("post_done", 32'(done_o), 32'd0);
    check("post_valid", 32'(sum_bit_valid_o), 32'd0);
    check("post_bit", 32'(sum_bit_o), 32'd0);
    check("hold_sum", 32'(sum_o), 32'(es));
    check("hold_cout", 32'(cout_o), 32'(ec));
  endtask

  vec_t vecs[8];
  int   cyc;

  initial begin
    vecs[0] = '{a: 8'h3C, b: 8'h0F, exp_sum: 8'h4B, exp_cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[2] = '{a: 8'h10, b: 8'h20, exp_sum: 8'h30, exp_cout: 1'b0};
    vecs[3] = '{a: 8'h01, b: 8'h02, exp_sum: 8'h03, exp_cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[5] = '{a: 8'hA5, b: 8'h5A, exp_sum: 8'hFF, exp_cout: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, exp_sum: 8'hFE, exp_cout: 1'b1};
    vecs[7] = '{a: 8'h7F, b: 8'h01, exp_sum: 8'h80, exp_cout: 1'b0};

    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_cout", 32'(cout_o), 32'd0);
    check("rst_valid", 32'(sum_bit_valid_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);

    // Start pulse while busy is ignored.
    @(negedge clk);
    a_i = 8'h10; b_i = 8'h20; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    a_i = 8'hAA; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 3;
    while (!done_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_rej_latency", 32'(cyc), 32'd8);
    check("busy_rej_sum", 32'(sum_o), 32'h30);

    // Back-to-back: start held during the done cycle.
    a_i = 8'h01; b_i = 8'h01; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("b2b_busy", 32'(busy_o), 32'd1);
    check("b2b_done_clear", 32'(done_o), 32'd0);
    check("b2b_sum_clear", 32'(sum_o), 32'd0);
    cyc = 0;
    while (!done_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", 32'(cyc), 32'd8);
    check("b2b_sum", 32'(sum_o), 32'h02);
    check("b2b_cout", 32'(cout_o), 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a_i = 8'hF0; b_i = 8'h0F; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(sum_bit_valid_o), 32'd0);
    check("arst_bit", 32'(sum_bit_o), 32'd0);
    check("arst_sum", 32'(sum_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o || busy_o) cyc++;
    end
    check("arst_no_resume", 32'(cyc), 32'd0);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b1);
    do_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    do_op(8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
